// File: rtl/tdc_pkg.sv
// Shared constants and state encoding for the TDC loopback pulse generator.
// Field layout of a 40-bit measurement word: {6'b0, coarse[27:0], fine[5:0]}.
package tdc_pkg;

    localparam int MEAS_W     = 40;
    localparam int COARSE_LSB = 6;
    localparam int COARSE_W   = 28;
    localparam int FINE_W     = 6;
    localparam int PULSE_W    = 8;
    localparam int REPEAT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SECOND = 2'd3
    } tdc_state_e;

endpackage

// File: rtl/tdc_pulse_gen.sv
// Generates a pair (or train) of pulses spaced C clk ticks apart for TDC loopback.
// Optional macro TDC_PULSE_GEN_REPEAT_EN adds repeat_count: 2+repeat_count rising edges per run.
module tdc_pulse_gen #(
    parameter int COARSE_W = tdc_pkg::COARSE_W,
    parameter int FINE_W   = tdc_pkg::FINE_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [tdc_pkg::MEAS_W-1:0]  interval,
    input  logic [tdc_pkg::PULSE_W-1:0] pulse_width,
`ifdef TDC_PULSE_GEN_REPEAT_EN
    input  logic [tdc_pkg::REPEAT_W-1:0] repeat_count,
`endif
    output logic                        signal_out,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [tdc_pkg::MEAS_W-1:0]  expected,
    output logic [1:0]                  state_out
);

    import tdc_pkg::*;

    tdc_state_e            state;
    logic [COARSE_W-1:0]   cnt;
    logic [COARSE_W-1:0]   coarse_last;
    logic [PULSE_W-1:0]    width_last;
    logic [REPEAT_W-1:0]   edges_left;

    logic [COARSE_W-1:0]   in_coarse;
    logic [FINE_W-1:0]     in_fine;
    logic [PULSE_W-1:0]    in_weff;
    logic                  in_invalid;
    logic [REPEAT_W-1:0]   in_repeat;
    logic [COARSE_W-1:0]   width_last_ext;
    logic                  unused_interval_bits;

    assign in_coarse  = interval[COARSE_LSB +: COARSE_W];
    assign in_fine    = interval[FINE_W-1:0];
    assign in_weff    = (pulse_width == '0) ? PULSE_W'(1) : pulse_width;
    // C < Weff+1 is the same as C <= Weff; widened so Weff never truncates.
    assign in_invalid = ({1'b0, in_coarse} <= (COARSE_W+1)'(in_weff));
    assign unused_interval_bits = ^interval[MEAS_W-1:COARSE_LSB+COARSE_W];

`ifdef TDC_PULSE_GEN_REPEAT_EN
    assign in_repeat = repeat_count;
`else
    assign in_repeat = '0;
`endif

    assign width_last_ext = COARSE_W'(width_last);
    assign busy           = (state != ST_IDLE);
    assign state_out      = state;

    // cnt counts cycles since the most recent rising edge: 0 in the first high cycle.
    // NOTE: every register is cleared by the async reset, including the latched
    // parameters and expected word, so a reset mid-run leaves no stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            signal_out  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            expected    <= '0;
            cnt         <= '0;
            coarse_last <= '0;
            width_last  <= '0;
            edges_left  <= '0;
        end else begin
            // NOTE: non-blocking defaults first; later assignments in this block win,
            // which turns done/err into single-cycle strobes.
            done <= 1'b0;
            err  <= 1'b0;

            if (state != ST_IDLE && abort) begin
                state      <= ST_IDLE;
                signal_out <= 1'b0;
                cnt        <= '0;
                edges_left <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            expected    <= MEAS_W'({in_coarse, in_fine});
                            coarse_last <= in_coarse - COARSE_W'(1);
                            width_last  <= in_weff - PULSE_W'(1);
                            edges_left  <= in_repeat;
                            cnt         <= '0;
                            if (in_invalid) begin
                                done <= 1'b1;
                                err  <= 1'b1;
                            end else begin
                                state      <= ST_FIRST;
                                signal_out <= 1'b1;
                            end
                        end
                    end

                    ST_FIRST, ST_SECOND: begin
                        cnt <= cnt + COARSE_W'(1);
                        if (cnt == width_last_ext) begin
                            signal_out <= 1'b0;
                            if (state == ST_FIRST) begin
                                state <= ST_WAIT;
                            end else if (edges_left != '0) begin
                                state      <= ST_WAIT;
                                edges_left <= edges_left - REPEAT_W'(1);
                            end else begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                                cnt   <= '0;
                            end
                        end
                    end

                    ST_WAIT: begin
                        // Counter reaches C in the cycle the next pulse goes high.
                        if (cnt == coarse_last) begin
                            state      <= ST_SECOND;
                            signal_out <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + COARSE_W'(1);
                        end
                    end

                    default: begin
                        state      <= ST_IDLE;
                        signal_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Self-checking bench for tdc_pulse_gen: vector table plus abort/reset/busy-start sequences.
// Define TDC_PULSE_GEN_REPEAT_EN for both bench and RTL to exercise the repeat train.
module tb_tdc_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [39:0] interval;
    logic [7:0]  pulse_width;
`ifdef TDC_PULSE_GEN_REPEAT_EN
    logic [7:0]  repeat_val;
`endif
    logic        signal_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [39:0] expected;
    logic [1:0]  state_out;

    int tests_run = 0;
    int tests_failed = 0;

    tdc_pulse_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .interval    (interval),
        .pulse_width (pulse_width),
`ifdef TDC_PULSE_GEN_REPEAT_EN
        .repeat_count(repeat_val),
`endif
        .signal_out  (signal_out),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .expected    (expected),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    typedef struct {
        logic [39:0] iv;
        logic [7:0]  w;
        logic [7:0]  rep;
        int          limit;
        int          n_rises;
        int          gap;
        int          high;
        int          done_k;
        logic        err;
        logic [39:0] exp_word;
    } vec_t;

    // Observations from the most recent run, indexed by cycle offset k from the start edge.
    int          n_rises;
    int          rise_k[8];
    int          high_len[8];
    int          done_k;
    logic        err_seen;
    logic        busy_seen;
    logic        done_level;
    logic [39:0] exp_seen;

    task automatic run_gen(input logic [39:0] iv, input logic [7:0] w, input logic [7:0] rep,
                           input int limit, input int poke_k, input logic [39:0] poke_iv);
        logic prev;
        n_rises = 0; done_k = -1; err_seen = 1'b0; busy_seen = 1'b0; done_level = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rise_k[i] = 0;
            high_len[i] = 0;
        end
        @(negedge clk);
        interval = iv; pulse_width = w; start = 1'b1;
`ifdef TDC_PULSE_GEN_REPEAT_EN
        repeat_val = rep;
`else
        if (rep != 8'd0) $display("note: repeat ignored in this build");
`endif
        @(negedge clk);
        start = 1'b0;
        exp_seen = expected;
        prev = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            if (k > 1) @(negedge clk);
            start = (k == poke_k);
            if (k == poke_k) interval = poke_iv;
            if (busy) busy_seen = 1'b1;
            if (err) err_seen = 1'b1;
            if (signal_out && !prev) begin
                if (n_rises < 8) rise_k[n_rises] = k;
                n_rises++;
            end
            if (signal_out && n_rises > 0 && n_rises <= 8) high_len[n_rises-1]++;
            if (done) begin
                done_k = k;
                done_level = signal_out;
                break;
            end
            prev = signal_out;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input vec_t v);
        check({tag, " rises"}, n_rises, v.n_rises);
        if (v.n_rises > 0) check({tag, " first_rise"}, rise_k[0], 1);
        for (int i = 1; i < v.n_rises && i < 8; i++)
            check($sformatf("%s gap%0d", tag, i), rise_k[i] - rise_k[i-1], v.gap);
        for (int i = 0; i < v.n_rises && i < 8; i++)
            check($sformatf("%s high%0d", tag, i), high_len[i], v.high);
        check({tag, " done_k"}, done_k, v.done_k);
        check({tag, " err"}, err_seen, v.err);
        check({tag, " busy"}, busy_seen, (v.n_rises > 0));
        check({tag, " expected"}, exp_seen, v.exp_word);
        check({tag, " out_at_done"}, done_level, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        logic flag;
        logic [39:0] exp_before;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; interval = '0; pulse_width = '0;
`ifdef TDC_PULSE_GEN_REPEAT_EN
        repeat_val = '0;
`endif
        //        iv                            w       rep    lim  rises gap  high done err exp
        vecs.push_back('{{6'h0, 28'd100, 6'd17}, 8'd4,   8'd0, 200, 2, 100, 4,   105, 1'b0, 40'h1911});
        vecs.push_back('{{6'h0, 28'd2,   6'd0},  8'd0,   8'd0, 20,  2, 2,   1,   4,   1'b0, 40'h80});
        vecs.push_back('{{6'h0, 28'd4,   6'd5},  8'd4,   8'd0, 20,  0, 0,   0,   1,   1'b1, 40'h105});
        vecs.push_back('{{6'h0, 28'd5,   6'd63}, 8'd4,   8'd0, 30,  2, 5,   4,   10,  1'b0, 40'h17F});
        vecs.push_back('{{6'h0, 28'd7,   6'd1},  8'd3,   8'd0, 30,  2, 7,   3,   11,  1'b0, 40'h1C1});
        vecs.push_back('{{6'h0, 28'd0,   6'd0},  8'd1,   8'd0, 20,  0, 0,   0,   1,   1'b1, 40'h0});
        vecs.push_back('{{6'h0, 28'd3,   6'd2},  8'd255, 8'd0, 20,  0, 0,   0,   1,   1'b1, 40'hC2});
        vecs.push_back('{{6'h0, 28'd300, 6'd0},  8'd255, 8'd0, 700, 2, 300, 255, 556, 1'b0, 40'h4B00});
        vecs.push_back('{{6'h3F, 28'd20, 6'd9},  8'd2,   8'd0, 60,  2, 20,  2,   23,  1'b0, 40'h509});
        vecs.push_back('{{6'h0, 28'd1,   6'd0},  8'd0,   8'd0, 20,  0, 0,   0,   1,   1'b1, 40'h40});
`ifdef TDC_PULSE_GEN_REPEAT_EN
        vecs.push_back('{{6'h0, 28'd10,  6'd0},  8'd2,   8'd2, 60,  4, 10,  2,   33,  1'b0, 40'h280});
`endif

        repeat (3) @(negedge clk);
        check("reset signal_out", signal_out, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset err", err, 1'b0);
        check("reset expected", expected, 40'h0);
        check("reset state", state_out, 2'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_gen(vecs[i].iv, vecs[i].w, vecs[i].rep, vecs[i].limit, 0, '0);
            check_run($sformatf("vec%0d", i), vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Start while busy: a second (invalid) request during WAIT must not disturb the run.
        run_gen({6'h0, 28'd20, 6'd3}, 8'd2, 8'd0, 60, 5, {6'h0, 28'd4, 6'd0});
        check_run("busy_start", '{{6'h0, 28'd20, 6'd3}, 8'd2, 8'd0, 60, 2, 20, 2, 23, 1'b0, 40'h503});
        repeat (2) @(negedge clk);

        // Abort during WAIT, with a simultaneous start that must be ignored.
        @(negedge clk);
        interval = {6'h0, 28'd50, 6'd0}; pulse_width = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort pre_state", state_out, 2'd2);
        abort = 1'b1; start = 1'b1; interval = {6'h0, 28'd8, 6'd0};
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort signal_out", signal_out, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort state", state_out, 2'd0);
        flag = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done || err || signal_out || busy) flag = 1'b1;
            @(negedge clk);
        end
        check("abort quiet", flag, 1'b0);
        check("abort expected", expected, 40'hC80);

        // start together with abort in IDLE: nothing happens.
        exp_before = expected;
        start = 1'b1; abort = 1'b1; interval = {6'h0, 28'd30, 6'd1}; pulse_width = 8'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort busy", busy, 1'b0);
        check("idle_abort done", done, 1'b0);
        check("idle_abort signal", signal_out, 1'b0);
        check("idle_abort expected", expected, exp_before);

        // Asynchronous reset during SECOND.
        @(negedge clk);
        interval = {6'h0, 28'd10, 6'd0}; pulse_width = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("rst_mid pre_state", state_out, 2'd3);
        check("rst_mid pre_signal", signal_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid signal_out", signal_out, 1'b0);
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid state", state_out, 2'd0);
        check("rst_mid expected", expected, 40'h0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || signal_out || busy) flag = 1'b1;
        end
        check("rst_mid quiet", flag, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tdc_pulse_gen.md
TDC_PULSE_GEN -- requirements
Module: tdc_pulse_gen

Interface
REQ-001 Parameter COARSE_W, default 28: width of the coarse interval field, in clk ticks.
REQ-002 Parameter FINE_W, default 6: width of the fine field, carried through only.
REQ-003 Ports shall be:
  clk          input   1    100 MHz clock
  rst_n        input   1    reset, asynchronous, active-low
  start        input   1    request one generation run
  abort        input   1    cancel the run in progress
  interval     input   40   [39:34] ignored, [33:6] coarse C, [5:0] fine F
  pulse_width  input   8    high time W per pulse in cycles; 0 is treated as 1
  signal_out   output  1    registered pulse output, for loopback into the TDC signal input
  busy         output  1    high when state is not IDLE
  done         output  1    one-cycle completion strobe
  err          output  1    one-cycle strobe for invalid parameters, coincident with done
  expected     output  40   {6'b0, C, F} latched at start, for loopback comparison
  state_out    output  2    current state, for LED display

Function
REQ-004 States shall be IDLE=0, FIRST=1, WAIT=2, SECOND=3, and state_out shall equal the state.
REQ-005 In IDLE, start=1 with abort=0 at edge t shall latch C, F and Weff=max(W,1), and shall load expected.
REQ-006 Parameters are invalid if C < Weff+1; invalid start shall pulse done=err=1 at t+1, emit no edges, and keep busy at 0.
REQ-007 A valid start shall raise signal_out at t+1, enter FIRST, and clear a COARSE_W-bit tick counter to 0.
REQ-008 The counter shall increment every cycle after the first rising edge; the block shall not depend on wrap-around, because C < 2^COARSE_W.
REQ-009 signal_out shall be high for exactly Weff cycles from each rising edge, then low.
REQ-010 FIRST->WAIT shall occur when the first pulse ends; WAIT->SECOND shall occur when the counter equals C, with signal_out rising in that cycle.
REQ-011 The second rising edge shall be exactly C cycles after the first.
REQ-012 After the last high cycle of the final pulse, the next cycle shall have signal_out=0, done=1 and state IDLE.
REQ-013 start while busy shall be ignored.
REQ-014 abort in any non-IDLE state shall force signal_out=0 and state=IDLE on the next edge, with no done and no err.
REQ-015 start and abort together in IDLE: abort wins and nothing happens.
REQ-016 The fine field shall not affect timing; it is only echoed in expected.

Reset
REQ-017 rst_n low shall immediately force state=IDLE, signal_out=0, busy=0, done=0, err=0, expected=0, and counter=0.
REQ-018 Reset mid-run shall abandon the run, and done shall not assert afterwards.

Configuration
REQ-019 Macro TDC_PULSE_GEN_REPEAT_EN, when defined, shall add input repeat[7:0], latched at start.
REQ-020 With the macro defined, the run shall emit 2+repeat rising edges, each exactly C cycles after the previous one, each Weff wide.
REQ-021 With the macro defined, SECOND shall return to WAIT while edges remain, and done shall follow the last pulse.
REQ-022 Without the macro, no repeat port shall exist, and exactly 2 edges shall be emitted.

Structure
REQ-023 Shared package tdc_pkg shall hold: state encodings, MEAS_W=40, COARSE_LSB=6, COARSE_W=28, FINE_W=6.
REQ-024 tdc_core shall use the same tdc_pkg field constants.
REQ-025 The block shall be a single module with no sub-module; one counter and the FSM are sufficient.

Verification
REQ-026 C=100, F=17, W=4, start at t -> rises at t+1 and t+101, each 4 cycles high, done at t+105, expected=0x0000001911.
REQ-027 C=2, W=0 -> rises at t+1 and t+3, each 1 cycle high, done at t+4, err=0.
REQ-028 C=4, W=4 -> done=err=1 at t+1, signal_out stays 0, busy stays 0.
REQ-029 abort in WAIT -> next cycle signal_out=0, busy=0; done never asserts; start in the same cycle as that abort is also ignored.
REQ-030 rst_n low during SECOND -> signal_out=busy=0 immediately, without waiting for clk; no done after release.
REQ-031 Macro defined, C=10, W=2, repeat=2 -> rises at t+1, t+11, t+21, t+31, done at t+33.
